// File: rtl/mealy_ctrl_pkg.sv
// mealy_ctrl_pkg: shared types and default widths for the Mealy step controller
package mealy_ctrl_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int SW_W_DEF = 2;
  localparam int ST_W_DEF = 3;
  typedef enum logic [2:0] {IDLE, INIT, APPLY, WAIT_BTN, STEP, CHECK, DONE} ctrl_state_t;
  typedef struct packed {
    logic [SW_W_DEF-1:0] sw;
    logic [ST_W_DEF-1:0] state;
    logic                out;
  } prog_entry_t;
endpackage

// File: rtl/mealy_prog_mem.sv
// mealy_prog_mem: program entry register file, sync write, two async read ports
module mealy_prog_mem import mealy_ctrl_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  prog_entry_t   wr_data,
  input  logic [AW-1:0] rd_addr,
  output prog_entry_t   rd_data,
  input  logic [AW-1:0] sw_addr,
  output prog_entry_t   sw_data
);
  prog_entry_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
  assign sw_data = mem[sw_addr];
endmodule

// File: rtl/mealy_step_ctrl.sv
// mealy_step_ctrl: steps a Mealy machine through a programmed list and checks each result
module mealy_step_ctrl import mealy_ctrl_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int SW_W = SW_W_DEF,
  parameter int ST_W = ST_W_DEF,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            prog_we,
  input  logic [AW-1:0]   prog_addr,
  input  logic [SW_W-1:0] prog_sw,
  input  logic [ST_W-1:0] prog_state,
  input  logic            prog_out,
  input  logic [ST_W-1:0] init_state,
  input  logic [AW:0]     len,
  input  logic            start,
  input  logic            single,
  input  logic            step_btn,
  output logic [SW_W-1:0] fsm_sw,
  output logic            fsm_ctrl,
  output logic            fsm_reset,
  output logic [ST_W-1:0] fsm_state_init,
  input  logic [ST_W-1:0] fsm_state,
  input  logic            fsm_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [AW:0]     err_cnt,
  output logic [AW-1:0]   err_idx,
  output logic [AW-1:0]   cur_idx
);
  ctrl_state_t state_q, state_d;
  logic [AW:0] len_q, err_d;
  logic [AW-1:0] idx_d, eidx_d;
  logic [SW_W-1:0] sw_d;
  logic single_q, btn_q, idle, mismatch, last;
  prog_entry_t wr_ent, chk_ent, sw_ent;
  assign wr_ent = '{sw: prog_sw, state: prog_state, out: prog_out};
  mealy_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk), .we(prog_we && !busy), .wr_addr(prog_addr), .wr_data(wr_ent),
    .rd_addr(cur_idx), .rd_data(chk_ent), .sw_addr(idx_d), .sw_data(sw_ent)
  );
  assign idle = state_q == IDLE || state_q == DONE;
  assign mismatch = {fsm_state, fsm_out} != {chk_ent.state, chk_ent.out};
  assign last = ({1'b0, cur_idx} + (AW+1)'(1)) == len_q;
  // fsm_sw is loaded from the entry the next state will apply, so it is valid from APPLY on
  always_comb begin
    state_d = state_q;
    idx_d = cur_idx;
    err_d = err_cnt;
    eidx_d = err_idx;
    sw_d = fsm_sw;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = INIT;
        idx_d = '0;
        err_d = '0;
        eidx_d = '0;
      end
      INIT: begin
        state_d = len_q == '0 ? DONE : APPLY;
        sw_d = len_q == '0 ? fsm_sw : sw_ent.sw;
      end
      APPLY: state_d = single_q ? WAIT_BTN : STEP;
      WAIT_BTN: state_d = step_btn && !btn_q ? STEP : WAIT_BTN;
      STEP: state_d = CHECK;
      CHECK: begin
        err_d = err_cnt + (AW+1)'(mismatch);
        eidx_d = mismatch && err_cnt == '0 ? cur_idx : err_idx;
        state_d = last ? DONE : APPLY;
        idx_d = last ? cur_idx : cur_idx + AW'(1);
        sw_d = last ? fsm_sw : sw_ent.sw;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    btn_q <= step_btn;
    if (reset) begin
      state_q <= IDLE;
      cur_idx <= '0;
      err_cnt <= '0;
      err_idx <= '0;
      fsm_sw <= '0;
      fsm_reset <= 1'b0;
      fsm_ctrl <= 1'b0;
      fsm_state_init <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      len_q <= '0;
      single_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_idx <= idx_d;
      err_cnt <= err_d;
      err_idx <= eidx_d;
      fsm_sw <= sw_d;
      fsm_reset <= state_d == INIT;
      fsm_ctrl <= state_d == STEP;
      busy <= !(state_d == IDLE || state_d == DONE);
      done <= state_d == DONE;
      pass <= state_d == DONE && err_d == '0;
      if (idle && start) begin
        fsm_state_init <= init_state;
        len_q <= len;
        single_q <= single;
      end
    end
  end
endmodule

// File: tb/tb_mealy_step_ctrl.sv
// tb_mealy_step_ctrl: timeline-model checks of the step controller driving a table-based Mealy machine
module tb_mealy_step_ctrl;
  logic clk = 0, reset = 1;
  logic prog_we = 0, prog_out = 0, start = 0, single = 0, step_btn = 0;
  logic [3:0] prog_addr = 0;
  logic [1:0] prog_sw = 0;
  logic [2:0] prog_state = 0, init_state = 0;
  logic [4:0] len = 0;
  logic [1:0] fsm_sw;
  logic fsm_ctrl, fsm_reset, busy, done, pass;
  logic [2:0] fsm_state_init;
  logic [4:0] err_cnt;
  logic [3:0] err_idx, cur_idx;
  logic [2:0] m_state = 0;
  logic m_out = 0;

  mealy_step_ctrl dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_sw(prog_sw),
    .prog_state(prog_state), .prog_out(prog_out), .init_state(init_state), .len(len),
    .start(start), .single(single), .step_btn(step_btn), .fsm_sw(fsm_sw), .fsm_ctrl(fsm_ctrl),
    .fsm_reset(fsm_reset), .fsm_state_init(fsm_state_init), .fsm_state(m_state), .fsm_out(m_out),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .err_idx(err_idx), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  // controlled machine: transition/output tables, loaded by fsm_reset, stepped by fsm_ctrl
  logic [2:0] next_tab [8][4];
  logic out_tab [8][4];
  always @(posedge clk)
    if (fsm_reset) begin
      m_state <= fsm_state_init;
      m_out <= 1'b0;
    end else if (fsm_ctrl) begin
      m_state <= next_tab[m_state][fsm_sw];
      m_out <= out_tab[m_state][fsm_sw];
    end

  logic [1:0] psw [16];
  logic [2:0] pst [16];
  logic pout [16];
  bit mis [16];
  int vectors = 0, miscompares = 0;
  int t = 0, run_len = 0, done_t = -1, ctrl_cnt = 0;
  logic [2:0] run_init = 0;
  bit mon_on = 0;
  int mk, mph, e_err, e_idx;
  bit e_done;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at t=%0d: got %0d, expected %0d", name, t, act, exp);
    end
  endtask

  // expected mismatch of each entry, found by walking the machine tables from init
  task automatic model_run(input int l, input logic [2:0] init);
    logic [2:0] s, ns;
    logic o;
    s = init;
    for (int k = 0; k < 16; k++) mis[k] = 0;
    for (int k = 0; k < l; k++) begin
      ns = next_tab[s][psw[k]];
      o = out_tab[s][psw[k]];
      mis[k] = {ns, o} != {pst[k], pout[k]};
      s = ns;
    end
  endtask

  always @(negedge clk) begin
    if (fsm_ctrl) ctrl_cnt++;
    if (mon_on) begin
      t = t + 1;
      e_done = t >= 3 * run_len + 2;
      mk = (t >= 2 && !e_done) ? (t - 2) / 3 : -1;
      mph = (t - 2) % 3;
      e_err = 0;
      e_idx = 0;
      for (int j = 0; j < run_len; j++)
        if (mis[j] && 3 * j + 5 <= t) begin
          if (e_err == 0) e_idx = j;
          e_err++;
        end
      chk("busy", busy, !e_done);
      chk("done", done, e_done);
      chk("pass", pass, e_done && e_err == 0);
      chk("fsm_reset", fsm_reset, t == 1);
      chk("fsm_ctrl", fsm_ctrl, mk >= 0 && mph == 1);
      chk("fsm_state_init", fsm_state_init, run_init);
      chk("err_cnt", err_cnt, e_err);
      chk("err_idx", err_idx, e_idx);
      chk("cur_idx", cur_idx, mk >= 0 ? mk : (e_done && run_len > 0 ? run_len - 1 : 0));
      if (mk >= 0) chk("fsm_sw", fsm_sw, psw[mk]);
      else if (e_done && run_len > 0) chk("fsm_sw_hold", fsm_sw, psw[run_len - 1]);
      if (done && done_t < 0) done_t = t;
    end
  end

  task automatic load_prog();
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      prog_we = 1; prog_addr = 4'(k); prog_sw = psw[k]; prog_state = pst[k]; prog_out = pout[k];
    end
    @(posedge clk); #1 prog_we = 0;
  endtask

  // auto run checked every cycle; disturb pokes start and a write mid-run
  task automatic run_auto(input int l, input logic [2:0] init, input bit disturb);
    model_run(l, init);
    run_len = l; run_init = init; done_t = -1;
    @(posedge clk); #1;
    len = 5'(l); init_state = init; single = 0; start = 1;
    @(posedge clk); #1;
    start = 0; t = 0; mon_on = 1;
    repeat (3 * l + 4) begin
      @(posedge clk); #1;
      if (disturb && t == 4) begin
        start = 1; prog_we = 1; prog_addr = 0;
        prog_sw = ~psw[0]; prog_state = ~pst[0]; prog_out = ~pout[0]; len = 0;
      end else begin
        start = 0; prog_we = 0;
      end
    end
    mon_on = 0;
  endtask

  task automatic set_golden(input bit faulty);
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++) begin next_tab[s][w] = 0; out_tab[s][w] = 0; end
    next_tab[0] = '{3'd0, 3'd0, 3'd1, 3'd1}; out_tab[0] = '{1'b1, 1'b0, 1'b1, 1'b1};
    next_tab[1] = '{3'd0, 3'd1, 3'd1, 3'd1}; out_tab[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    if (faulty) begin next_tab[0][2] = 0; out_tab[1][0] = 1; end
  endtask

  task automatic golden_prog();
    for (int k = 0; k < 16; k++) begin psw[k] = 0; pst[k] = 0; pout[k] = 0; end
    psw[0] = 3; pst[0] = 1; pout[0] = 1;
    psw[1] = 1; pst[1] = 1; pout[1] = 1;
    psw[2] = 0; pst[2] = 0; pout[2] = 0;
    psw[3] = 2; pst[3] = 1; pout[3] = 1;
  endtask

  task automatic rand_setup(output int l, output logic [2:0] init);
    logic [2:0] s, ns;
    logic o;
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 4; w++) begin
        next_tab[i][w] = 3'($urandom_range(0, 7)); out_tab[i][w] = 1'($urandom_range(0, 1));
      end
    init = 3'($urandom_range(0, 7));
    s = init;
    for (int k = 0; k < 16; k++) begin
      psw[k] = 2'($urandom_range(0, 3));
      ns = next_tab[s][psw[k]];
      o = out_tab[s][psw[k]];
      if ($urandom_range(0, 3) != 0) begin pst[k] = ns; pout[k] = o; end
      else begin pst[k] = 3'($urandom_range(0, 7)); pout[k] = 1'($urandom_range(0, 1)); end
      s = ns;
    end
    l = $urandom_range(0, 16);
  endtask

  initial begin
    int l, c0;
    logic [2:0] ini;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_fsm_sw", fsm_sw, 0); chk("rst_fsm_ctrl", fsm_ctrl, 0); chk("rst_fsm_reset", fsm_reset, 0);
    chk("rst_state_init", fsm_state_init, 0); chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_idx", err_idx, 0); chk("rst_cur_idx", cur_idx, 0);
    reset = 0;

    set_golden(0); golden_prog(); load_prog();
    run_auto(4, 0, 0);
    chk("gold_done_cycle", done_t, 14); chk("gold_err_cnt", err_cnt, 0); chk("gold_pass", pass, 1);

    set_golden(1);
    run_auto(4, 0, 1);
    chk("faulty_err_cnt", err_cnt, 2); chk("faulty_err_idx", err_idx, 2); chk("faulty_pass", pass, 0);
    set_golden(0);
    run_auto(4, 0, 0);
    chk("mem_unchanged_pass", pass, 1);

    c0 = ctrl_cnt;
    run_auto(0, 3'd5, 0);
    chk("len0_done_cycle", done_t, 2); chk("len0_ctrl_pulses", ctrl_cnt - c0, 0); chk("len0_pass", pass, 1);

    @(posedge clk); #1 len = 4; init_state = 0; single = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (5) @(posedge clk);
    #1 chk("mid_ctrl_before_reset", fsm_ctrl, 1);
    reset = 1;
    @(posedge clk); #1;
    chk("mid_busy", busy, 0); chk("mid_done", done, 0); chk("mid_err_cnt", err_cnt, 0);
    chk("mid_cur_idx", cur_idx, 0); chk("mid_fsm_ctrl", fsm_ctrl, 0); chk("mid_fsm_reset", fsm_reset, 0);
    reset = 0;
    run_auto(4, 0, 0);

    @(posedge clk); #1 len = 2; init_state = 0; single = 1; start = 1;
    @(posedge clk); #1 start = 0; c0 = ctrl_cnt;
    repeat (20) @(posedge clk);
    #1 chk("single_wait_busy", busy, 1); chk("single_wait_pulses", ctrl_cnt - c0, 0); chk("single_wait_idx", cur_idx, 0);
    step_btn = 1;
    repeat (10) @(posedge clk);
    #1 chk("single_held_pulses", ctrl_cnt - c0, 1); chk("single_held_idx", cur_idx, 1); chk("single_held_busy", busy, 1);
    step_btn = 0;
    repeat (3) @(posedge clk);
    #1 step_btn = 1;
    repeat (10) @(posedge clk);
    #1 chk("single_2_pulses", ctrl_cnt - c0, 2); chk("single_done", done, 1);
    chk("single_pass", pass, 1); chk("single_err_cnt", err_cnt, 0);
    step_btn = 0; single = 0;

    for (int r = 0; r < 12; r++) begin
      rand_setup(l, ini);
      load_prog();
      run_auto(l, ini, r % 4 == 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
